div_share_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one go/done divider (`divide`-style: dividend/divisor in, quotient out, level go, level done) among NREQ clients.
- Per client: latches operands, drives the divider's 4-phase go/done handshake, returns the quotient with a one-cycle ack.
- Sits between client FSMs and the single divider instance in the datapath.

---
 rtl/div_share_arbiter.sv | 153 +++++++++++++++
 tb/tb_div_share_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/div_share_arbiter.sv
// Round-robin arbiter sharing one go/done divider among NREQ clients.
// Optional macro DIV_SHARE_ZERO_BYPASS_EN answers zero-divisor requests locally with div0_err.
module div_share_arbiter #(
    parameter int NREQ = 4,
    parameter int DD_W = 16,
    parameter int DV_W = 8,
    parameter int Q_W  = 8
) (
    input  logic                 clk,
    input  logic                 reset_L,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*DD_W-1:0] dd_in,
    input  logic [NREQ*DV_W-1:0] dv_in,
    output logic [NREQ-1:0]      ack,
    output logic [Q_W-1:0]       rsp_q,
    output logic                 busy,
    output logic                 div_go,
    output logic [DD_W-1:0]      div_dd,
    output logic [DV_W-1:0]      div_dv,
    input  logic [Q_W-1:0]       div_q,
`ifdef DIV_SHARE_ZERO_BYPASS_EN
    output logic                 div0_err,
`endif
    input  logic                 div_done
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, RESP, RELEASE} state_t;

    state_t           state_reg, state_next;
    logic [IDX_W-1:0] rr_ptr_reg, rr_ptr_next;
    logic [IDX_W-1:0] gnt_idx_reg, gnt_idx_next;
    logic [DD_W-1:0]  dd_reg, dd_next;
    logic [DV_W-1:0]  dv_reg, dv_next;
    logic [Q_W-1:0]   q_reg, q_next;
`ifdef DIV_SHARE_ZERO_BYPASS_EN
    logic             zero_reg, zero_next;
`endif

    logic [DD_W-1:0]  dd_arr [NREQ];
    logic [DV_W-1:0]  dv_arr [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_client
            assign dd_arr[gi] = dd_in[gi*DD_W +: DD_W];
            assign dv_arr[gi] = dv_in[gi*DV_W +: DV_W];
            assign ack[gi]    = (state_reg == RESP) && (gnt_idx_reg == IDX_W'(gi));
        end
    endgenerate

    // Scan from the farthest offset down so the nearest requester at/after rr_ptr wins.
    logic             win_found;
    logic [IDX_W-1:0] win_idx;
    int               cand;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = int'(rr_ptr_reg) + k;
            if (cand >= NREQ) cand = cand - NREQ;
            if (req[IDX_W'(cand)]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(cand);
            end
        end
    end

    always_comb begin
        state_next   = state_reg;
        rr_ptr_next  = rr_ptr_reg;
        gnt_idx_next = gnt_idx_reg;
        dd_next      = dd_reg;
        dv_next      = dv_reg;
        q_next       = q_reg;
`ifdef DIV_SHARE_ZERO_BYPASS_EN
        zero_next    = zero_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (win_found && div_done) begin
                    gnt_idx_next = win_idx;
`ifdef DIV_SHARE_ZERO_BYPASS_EN
                    if (dv_arr[win_idx] == '0) begin
                        q_next     = '0;
                        zero_next  = 1'b1;
                        state_next = RESP;
                    end else begin
                        dd_next    = dd_arr[win_idx];
                        dv_next    = dv_arr[win_idx];
                        zero_next  = 1'b0;
                        state_next = LAUNCH;
                    end
`else
                    dd_next    = dd_arr[win_idx];
                    dv_next    = dv_arr[win_idx];
                    state_next = LAUNCH;
`endif
                end
            end
            LAUNCH: state_next = WAIT;
            WAIT: begin
                if (div_done) begin
                    q_next     = div_q;
                    state_next = RESP;
                end
            end
            RESP: begin
                rr_ptr_next = (gnt_idx_reg == IDX_W'(NREQ - 1)) ? '0 : gnt_idx_reg + 1'b1;
                state_next  = RELEASE;
            end
            RELEASE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            state_reg   <= IDLE;
            rr_ptr_reg  <= '0;
            gnt_idx_reg <= '0;
            dd_reg      <= '0;
            dv_reg      <= '0;
            q_reg       <= '0;
`ifdef DIV_SHARE_ZERO_BYPASS_EN
            zero_reg    <= 1'b0;
`endif
        end else begin
            state_reg   <= state_next;
            rr_ptr_reg  <= rr_ptr_next;
            gnt_idx_reg <= gnt_idx_next;
            dd_reg      <= dd_next;
            dv_reg      <= dv_next;
            q_reg       <= q_next;
`ifdef DIV_SHARE_ZERO_BYPASS_EN
            zero_reg    <= zero_next;
`endif
        end
    end

    // go is decoded from the state register so a reset drops it on the same edge.
    assign div_go = (state_reg == LAUNCH) || (state_reg == WAIT);
    assign busy   = (state_reg != IDLE);
    assign rsp_q  = q_reg;
    assign div_dd = dd_reg;
    assign div_dv = dv_reg;
`ifdef DIV_SHARE_ZERO_BYPASS_EN
    assign div0_err = (state_reg == RESP) && zero_reg;
`endif

endmodule

// File: tb/tb_div_share_arbiter.sv
// Directed bench for div_share_arbiter with a behavioural go/done divider of adjustable latency.
module tb_div_share_arbiter;
    localparam int NREQ = 4, DD_W = 16, DV_W = 8, Q_W = 8;

    logic                 clk = 1'b0;
    logic                 reset_L = 1'b0;
    logic [NREQ-1:0]      req = '0;
    logic [NREQ*DD_W-1:0] dd_in = '0;
    logic [NREQ*DV_W-1:0] dv_in = '0;
    logic [NREQ-1:0]      ack;
    logic [Q_W-1:0]       rsp_q;
    logic                 busy, div_go;
    logic [DD_W-1:0]      div_dd;
    logic [DV_W-1:0]      div_dv;
    logic [Q_W-1:0]       div_q;
    logic                 div_done = 1'b1;
`ifdef DIV_SHARE_ZERO_BYPASS_EN
    logic                 div0_err;
`endif
    int div_lat = 0;
    int div_cnt = 0;
    int total = 0;
    int bad = 0;
    int cyc, go_cyc;

    div_share_arbiter #(.NREQ(NREQ), .DD_W(DD_W), .DV_W(DV_W), .Q_W(Q_W)) dut (
        .clk(clk), .reset_L(reset_L), .req(req), .dd_in(dd_in), .dv_in(dv_in),
        .ack(ack), .rsp_q(rsp_q), .busy(busy), .div_go(div_go),
        .div_dd(div_dd), .div_dv(div_dv), .div_q(div_q),
`ifdef DIV_SHARE_ZERO_BYPASS_EN
        .div0_err(div0_err),
`endif
        .div_done(div_done)
    );

    always #5 clk = ~clk;

    // Divider: done idles high, drops for div_lat cycles after go, restarts once go falls.
    always @(posedge clk) begin
        if (!div_go) begin
            div_done <= 1'b1;
            div_cnt  <= 0;
        end else if (div_cnt < div_lat) begin
            div_done <= 1'b0;
            div_cnt  <= div_cnt + 1;
        end else begin
            div_done <= 1'b1;
        end
    end

    function automatic logic [Q_W-1:0] sdiv(input logic [DD_W-1:0] d, input logic [DV_W-1:0] v);
        int a, b;
        a = int'($signed(d));
        b = int'($signed(v));
        if (b == 0) return '0;
        return Q_W'(a / b);
    endfunction

    assign div_q = sdiv(div_dd, div_dv);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [DD_W-1:0] d, input logic [DV_W-1:0] v);
        dd_in[i*DD_W +: DD_W] = d;
        dv_in[i*DV_W +: DV_W] = v;
    endtask

    task automatic wait_ack(output int c, output int g);
        c = 0;
        g = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            c++;
            if (div_go) g++;
            if (ack != '0) break;
        end
        check("ack_seen", {31'd0, (ack != '0)}, 32'd1);
    endtask

    // Checks the ack cycle, drops the request, then checks the release cycle.
    task automatic finish_txn(input string tag, input int idx, input logic [Q_W-1:0] q);
        check({tag, "_ack"}, ack, 32'(1 << idx));
        check({tag, "_q"}, rsp_q, q);
        $display("txn %s client=%0d ack=%b rsp_q=%h", tag, idx, ack, rsp_q);
        req[idx] = 1'b0;
        tick();
        check({tag, "_rel_ack"}, ack, 0);
        check({tag, "_rel_go"}, div_go, 0);
        check({tag, "_rel_busy"}, busy, 1);
        check({tag, "_rel_q"}, rsp_q, q);
    endtask

    task automatic txn(input string tag, input int idx, input logic [Q_W-1:0] q,
                       input int exp_lat, input int exp_go);
        int c, g;
        wait_ack(c, g);
        check({tag, "_lat"}, c, exp_lat);
        check({tag, "_go"}, g, exp_go);
        finish_txn(tag, idx, q);
    endtask

    initial begin
        // Reset state
        tick(); tick(); tick();
        check("rst_ack", ack, 0);
        check("rst_busy", busy, 0);
        check("rst_go", div_go, 0);
        check("rst_dd", div_dd, 0);
        check("rst_dv", div_dv, 0);
        check("rst_q", rsp_q, 0);
        reset_L = 1'b1;
        tick();

        // Single client 0, 2-cycle divider: 100/7 = 14
        set_op(0, 16'd100, 8'd7);
        div_lat = 2;
        req[0] = 1'b1;
        txn("single0", 0, 8'h0E, 5, 4);
        tick();
        check("idle_busy", busy, 0);

        // Signed pass-through: -100/7 = -14
        set_op(1, 16'hFF9C, 8'd7);
        div_lat = 0;
        req[1] = 1'b1;
        txn("signed1", 1, 8'hF2, 3, 2);
        check("signed_dd", div_dd, 16'hFF9C);
        check("signed_dv", div_dv, 8'd7);

        // rr_ptr=2 with req=1011: 3 first, then wrap to 0, then 1
        set_op(3, 16'd200, 8'd10);
        req = 4'b1011;
        txn("rr3", 3, 8'h14, 4, 2);
        txn("rr0", 0, 8'h0E, 4, 2);
        txn("rr1", 1, 8'hF2, 4, 2);
        tick();

        // Reset during WAIT with a slow divider
        div_lat = 10;
        req[0] = 1'b1;
        tick(); tick(); tick();
        check("wait_go", div_go, 1);
        check("wait_busy", busy, 1);
        reset_L = 1'b0;
        req = '0;
        tick();
        check("midrst_go", div_go, 0);
        check("midrst_ack", ack, 0);
        check("midrst_busy", busy, 0);
        reset_L = 1'b1;
        div_lat = 0;
        req[3] = 1'b1;
        txn("after_rst3", 3, 8'h14, 4, 2);
        tick();

        // All four at once from rr_ptr=0: 0,1,2,3 spaced 5 cycles apart
        set_op(2, 16'd81, 8'd9);
        req = 4'b1111;
        txn("all0", 0, 8'h0E, 3, 2);
        txn("all1", 1, 8'hF2, 4, 2);
        txn("all2", 2, 8'h09, 4, 2);
        txn("all3", 3, 8'h14, 4, 2);
        tick();

        // Clients 0 and 2 with rr_ptr=0
        req = 4'b0101;
        txn("pair0", 0, 8'h0E, 3, 2);
        txn("pair2", 2, 8'h09, 4, 2);
        tick();

        // Slow divider: 1000/9 = 111
        set_op(1, 16'd1000, 8'd9);
        div_lat = 10;
        req[1] = 1'b1;
        txn("slow1", 1, 8'h6F, 13, 12);
        tick();

        // Zero divisor on client 2
        set_op(2, 16'd50, 8'd0);
        div_lat = 0;
        req[2] = 1'b1;
        wait_ack(cyc, go_cyc);
`ifdef DIV_SHARE_ZERO_BYPASS_EN
        check("zero_lat", cyc, 1);
        check("zero_go", go_cyc, 0);
        check("zero_err", div0_err, 1);
        finish_txn("zero2", 2, 8'h00);
        check("zero_err_clr", div0_err, 0);
`else
        check("zero_lat", cyc, 3);
        check("zero_go", go_cyc, 2);
        finish_txn("zero2", 2, 8'h00);
`endif
        tick();
        check("end_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
